// File: rtl/wb_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// wb_bus_arbiter_if
//   Bundles every bus signal around the two-master / one-slave Wishbone-style
//   arbiter: both master request ports (M0 = core load/store, M1 = UART debug),
//   the shared slave port, the one-hot grant and the watchdog error pulse.
//
//   Handshake: a master asserts Mx_cs and holds Mx_addr/Mx_we/Mx_wdata stable
//   until Mx_ack is seen high; Mx_ack high for one cycle completes the transfer
//   (Mx_rdata is valid in that cycle). The master drops cs, or starts a new
//   request, on the cycle after ack. The slave side uses the same cs/ack rule.
//
//   Modports:
//     master : the arbiter's view (drives Wb_*, Mx_ack/Mx_rdata, Grant,
//              Timeout_err; receives Mx requests and the slave response)
//     slave  : the environment's view (masters + slave model), the mirror
//
//   `WORD_SIZE / `ADDR_SIZE default to 32 when not supplied externally.
// ----------------------------------------------------------------------------
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif

interface wb_bus_arbiter_if;
  // master 0 (core)
  logic [`ADDR_SIZE-1:0] M0_addr;
  logic                  M0_cs;
  logic                  M0_we;
  logic [`WORD_SIZE-1:0] M0_wdata;
  logic [`WORD_SIZE-1:0] M0_rdata;
  logic                  M0_ack;
  // master 1 (UART debug)
  logic [`ADDR_SIZE-1:0] M1_addr;
  logic                  M1_cs;
  logic                  M1_we;
  logic [`WORD_SIZE-1:0] M1_wdata;
  logic [`WORD_SIZE-1:0] M1_rdata;
  logic                  M1_ack;
  // shared slave
  logic [`ADDR_SIZE-1:0] Wb_addr;
  logic                  Wb_cs;
  logic                  Wb_we;
  logic [`WORD_SIZE-1:0] Wb_wdata;
  logic [`WORD_SIZE-1:0] Wb_rdata;
  logic                  Wb_ack;
  // status
  logic [1:0]            Grant;
  logic                  Timeout_err;

  modport master (
    input  M0_addr, M0_cs, M0_we, M0_wdata,
    output M0_rdata, M0_ack,
    input  M1_addr, M1_cs, M1_we, M1_wdata,
    output M1_rdata, M1_ack,
    output Wb_addr, Wb_cs, Wb_we, Wb_wdata,
    input  Wb_rdata, Wb_ack,
    output Grant, Timeout_err
  );

  modport slave (
    output M0_addr, M0_cs, M0_we, M0_wdata,
    input  M0_rdata, M0_ack,
    output M1_addr, M1_cs, M1_we, M1_wdata,
    input  M1_rdata, M1_ack,
    input  Wb_addr, Wb_cs, Wb_we, Wb_wdata,
    output Wb_rdata, Wb_ack,
    input  Grant, Timeout_err
  );
endinterface

// File: rtl/wb_bus_arbiter.sv
// ----------------------------------------------------------------------------
// wb_bus_arbiter
//   Shares one single-word Wishbone-style slave between the core load/store
//   port (M0) and the UART debug command path (M1). Arbitration is registered
//   (one cycle from request to Wb_cs), the grant is held until the slave acks,
//   and one dead REST cycle follows every completed transfer so the acked
//   master can drop cs before the next decision.
//
//   Ports:
//     Clk, Rst     clock, synchronous active-high reset
//     bus          wb_bus_arbiter_if.master (M0/M1 request ports, Wb slave
//                  port, Grant one-hot {M1,M0}, Timeout_err pulse)
//     o_dbg_state  current FSM state (IDLE=0, OWN0=1, OWN1=2, REST=3)
//
//   Parameters:
//     ROUND_ROBIN     1 = alternate on contention, 0 = M0 always wins
//     TIMEOUT_CYCLES  watchdog limit, grant to ack (1..255)
//     TIMEOUT_RDATA   read data returned to the owner on watchdog expiry
//
//   Optional feature macro: WB_ARB_TIMEOUT_EN
//     defined   : 8-bit watchdog; on expiry the owner gets a forced ack with
//                 TIMEOUT_RDATA, Timeout_err pulses and the FSM goes to REST
//     undefined : no watchdog, grant held until ack or abort, Timeout_err = 0
// ----------------------------------------------------------------------------
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif

module wb_bus_arbiter #(
  parameter int                    ROUND_ROBIN    = 1,
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter logic [`WORD_SIZE-1:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
  input  logic                  Clk,
  input  logic                  Rst,
  wb_bus_arbiter_if.master      bus,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2,
    REST = 2'd3
  } state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("wb_bus_arbiter: TIMEOUT_CYCLES must be in 1..255");
  end

  state_t     r_state;
  logic [1:0] r_grant;
  logic       r_last_owner;   // 0 = M0 served last, 1 = M1 served last

  logic       w_pick_m1;      // arbitration decision, used only in IDLE
  logic       w_owning;
  logic       w_limit;        // watchdog count has reached its limit
  logic       w_timeout;      // watchdog fires (no real ack this cycle)

  assign w_owning = (r_state == OWN0) || (r_state == OWN1);

  // On a tie, round-robin hands the bus to whichever master was not served
  // last; otherwise the lone requester wins, and M0 wins ties in fixed mode.
  always_comb begin
    w_pick_m1 = 1'b0;
    if (bus.M0_cs && bus.M1_cs) begin
      w_pick_m1 = (ROUND_ROBIN != 0) && (r_last_owner == 1'b0);
    end else begin
      w_pick_m1 = bus.M1_cs;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0] r_cnt;
  localparam logic [7:0] LP_LIMIT = 8'(TIMEOUT_CYCLES);

  // Wb_cs is dropped on w_limit alone (not gated by Wb_ack) so the slave
  // select never depends combinationally on the slave's own ack.
  assign w_limit = w_owning && (r_cnt == LP_LIMIT);
`else
  assign w_limit = 1'b0;
`endif

  // A real ack in the expiry cycle wins: normal completion, no error.
  assign w_timeout = w_limit && !bus.Wb_ack;

  // Single FSM: state, grant and last-owner are all registered here.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state      <= IDLE;
      r_grant      <= 2'b00;
      r_last_owner <= 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
      r_cnt        <= 8'd0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.M0_cs || bus.M1_cs) begin
`ifdef WB_ARB_TIMEOUT_EN
            r_cnt <= 8'd0;
`endif
            if (w_pick_m1) begin
              r_state <= OWN1;
              r_grant <= 2'b10;
            end else begin
              r_state <= OWN0;
              r_grant <= 2'b01;
            end
          end
        end

        OWN0, OWN1: begin
          if (bus.Wb_ack) begin
            r_state      <= REST;
            r_grant      <= 2'b00;
            r_last_owner <= (r_state == OWN1);
          end else if (w_limit) begin
            // watchdog expiry: transfer is closed, last_owner left alone
            r_state <= REST;
            r_grant <= 2'b00;
          end else if (((r_state == OWN0) && !bus.M0_cs) ||
                       ((r_state == OWN1) && !bus.M1_cs)) begin
            // owner aborted before the slave answered
            r_state <= IDLE;
            r_grant <= 2'b00;
          end else begin
`ifdef WB_ARB_TIMEOUT_EN
            r_cnt <= r_cnt + 8'd1;
`endif
          end
        end

        REST: begin
          r_state <= IDLE;
          r_grant <= 2'b00;
        end

        default: begin
          r_state <= IDLE;
          r_grant <= 2'b00;
        end
      endcase
    end
  end

  // Bus steering: the owner's request is passed straight through so a
  // zero-wait slave can answer in the first owned cycle. Read data goes to
  // both masters; only the owner's ack qualifies it.
  always_comb begin
    bus.Wb_addr  = '0;
    bus.Wb_cs    = 1'b0;
    bus.Wb_we    = 1'b0;
    bus.Wb_wdata = '0;
    bus.M0_ack   = 1'b0;
    bus.M1_ack   = 1'b0;
    bus.M0_rdata = bus.Wb_rdata;
    bus.M1_rdata = bus.Wb_rdata;
    case (r_state)
      OWN0: begin
        bus.Wb_addr  = bus.M0_addr;
        bus.Wb_cs    = bus.M0_cs && !w_limit;
        bus.Wb_we    = bus.M0_we;
        bus.Wb_wdata = bus.M0_wdata;
        bus.M0_ack   = bus.Wb_ack || w_timeout;
        if (w_timeout) bus.M0_rdata = TIMEOUT_RDATA;
      end
      OWN1: begin
        bus.Wb_addr  = bus.M1_addr;
        bus.Wb_cs    = bus.M1_cs && !w_limit;
        bus.Wb_we    = bus.M1_we;
        bus.Wb_wdata = bus.M1_wdata;
        bus.M1_ack   = bus.Wb_ack || w_timeout;
        if (w_timeout) bus.M1_rdata = TIMEOUT_RDATA;
      end
      default: ;
    endcase
  end

  assign bus.Grant       = r_grant;
  assign bus.Timeout_err = w_timeout;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_wb_bus_arbiter
//   Directed bench for wb_bus_arbiter. Two instances: u_rr (ROUND_ROBIN=1)
//   and u_fp (ROUND_ROBIN=0), both with TIMEOUT_CYCLES=4. Inputs change 2
//   time units after the rising edge, outputs are checked 1 unit later.
//   Build with +define+WB_ARB_TIMEOUT_EN to exercise the watchdog.
// ----------------------------------------------------------------------------
module tb_wb_bus_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_bus_arbiter_if ifc();
  wb_bus_arbiter_if ifc_fp();
  logic [1:0] dbg_rr;
  logic [1:0] dbg_fp;

  wb_bus_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(4)) u_rr (
    .Clk(clk), .Rst(rst), .bus(ifc.master), .o_dbg_state(dbg_rr)
  );

  wb_bus_arbiter #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(4)) u_fp (
    .Clk(clk), .Rst(rst), .bus(ifc_fp.master), .o_dbg_state(dbg_fp)
  );

  // ---------------- slave models ----------------
  // auto mode: zero-wait slave (ack whenever selected); otherwise manual.
  logic        auto_rr;
  logic        auto_fp;
  logic        man_ack;
  logic [31:0] man_rdata;

  always_comb begin
    ifc.Wb_ack      = auto_rr ? ifc.Wb_cs : man_ack;
    ifc.Wb_rdata    = auto_rr ? 32'hCAFE_0001 : man_rdata;
    ifc_fp.Wb_ack   = auto_fp ? ifc_fp.Wb_cs : 1'b0;
    ifc_fp.Wb_rdata = 32'hCAFE_0002;
  end

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic exp_m1;
    auto_rr = 1'b0; auto_fp = 1'b0; man_ack = 1'b0; man_rdata = 32'h0;
    ifc.M0_cs = 1'b0; ifc.M0_we = 1'b0; ifc.M0_addr = '0; ifc.M0_wdata = '0;
    ifc.M1_cs = 1'b0; ifc.M1_we = 1'b0; ifc.M1_addr = '0; ifc.M1_wdata = '0;
    ifc_fp.M0_cs = 1'b0; ifc_fp.M0_we = 1'b0; ifc_fp.M0_addr = '0; ifc_fp.M0_wdata = '0;
    ifc_fp.M1_cs = 1'b0; ifc_fp.M1_we = 1'b0; ifc_fp.M1_addr = '0; ifc_fp.M1_wdata = '0;

    // reset state
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("rst_grant", ifc.Grant, 2'b00);
    chk("rst_wb_cs", ifc.Wb_cs, 1'b0);
    chk("rst_m0_ack", ifc.M0_ack, 1'b0);
    chk("rst_m1_ack", ifc.M1_ack, 1'b0);
    chk("rst_state", dbg_rr, 2'd0);
    chk("rst_tmo_err", ifc.Timeout_err, 1'b0);
    chk("rst_fp_grant", ifc_fp.Grant, 2'b00);

    // M0 write, slave acks one cycle after Wb_cs
    ifc.M0_cs = 1'b1; ifc.M0_we = 1'b1; ifc.M0_addr = 32'h10; ifc.M0_wdata = 32'h1234_5678;
    #1;
    chk("t1_idle_wb_cs", ifc.Wb_cs, 1'b0);
    cyc(); #1;
    chk("t1_grant", ifc.Grant, 2'b01);
    chk("t1_wb_cs", ifc.Wb_cs, 1'b1);
    chk("t1_wb_addr", ifc.Wb_addr, 32'h10);
    chk("t1_wb_wdata", ifc.Wb_wdata, 32'h1234_5678);
    chk("t1_wb_we", ifc.Wb_we, 1'b1);
    chk("t1_m0_ack_wait", ifc.M0_ack, 1'b0);
    cyc();
    man_ack = 1'b1;
    #1;
    chk("t1_m0_ack", ifc.M0_ack, 1'b1);
    chk("t1_m1_ack", ifc.M1_ack, 1'b0);
    chk("t1_grant_hold", ifc.Grant, 2'b01);
    cyc();
    man_ack = 1'b0; ifc.M0_cs = 1'b0;
    #1;
    chk("t1_rest_grant", ifc.Grant, 2'b00);
    chk("t1_rest_wb_cs", ifc.Wb_cs, 1'b0);
    chk("t1_rest_state", dbg_rr, 2'd3);
    chk("t1_rest_m0_ack", ifc.M0_ack, 1'b0);
    cyc(); #1;
    chk("t1_idle_state", dbg_rr, 2'd0);

    // round-robin contention after reset, zero-wait slave
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    auto_rr = 1'b1;
    ifc.M0_cs = 1'b1; ifc.M0_we = 1'b1; ifc.M0_addr = 32'h20; ifc.M0_wdata = 32'hA0A0_A0A0;
    ifc.M1_cs = 1'b1; ifc.M1_we = 1'b0; ifc.M1_addr = 32'h30; ifc.M1_wdata = 32'h0;
    for (int k = 0; k < 4; k++) begin
      exp_m1 = (k % 2) == 1;
      cyc(); #1;
      chk("rr_grant", ifc.Grant, exp_m1 ? 2'b10 : 2'b01);
      chk("rr_wb_cs", ifc.Wb_cs, 1'b1);
      chk("rr_wb_addr", ifc.Wb_addr, exp_m1 ? 32'h30 : 32'h20);
      chk("rr_m0_ack", ifc.M0_ack, !exp_m1);
      chk("rr_m1_ack", ifc.M1_ack, exp_m1);
      if (exp_m1) chk("rr_m1_rdata", ifc.M1_rdata, 32'hCAFE_0001);
      cyc(); #1;
      chk("rr_rest_wb_cs", ifc.Wb_cs, 1'b0);
      chk("rr_rest_grant", ifc.Grant, 2'b00);
      cyc(); #1;
      chk("rr_idle_state", dbg_rr, 2'd0);
    end
    ifc.M0_cs = 1'b0; ifc.M1_cs = 1'b0; auto_rr = 1'b0;

    // fixed priority contention on the second instance
    auto_fp = 1'b1;
    ifc_fp.M0_cs = 1'b1; ifc_fp.M0_addr = 32'h40;
    ifc_fp.M1_cs = 1'b1; ifc_fp.M1_addr = 32'h48;
    for (int k = 0; k < 4; k++) begin
      cyc(); #1;
      chk("fp_grant", ifc_fp.Grant, 2'b01);
      chk("fp_wb_addr", ifc_fp.Wb_addr, 32'h40);
      chk("fp_m0_ack", ifc_fp.M0_ack, 1'b1);
      chk("fp_m1_ack", ifc_fp.M1_ack, 1'b0);
      cyc(); #1;
      chk("fp_rest_m1_ack", ifc_fp.M1_ack, 1'b0);
      cyc();
    end
    ifc_fp.M0_cs = 1'b0; ifc_fp.M1_cs = 1'b0; auto_fp = 1'b0;

    // abort by M1, then spurious ack in IDLE
    ifc.M1_cs = 1'b1; ifc.M1_we = 1'b0; ifc.M1_addr = 32'h44;
    cyc(); #1;
    chk("ab_grant", ifc.Grant, 2'b10);
    chk("ab_wb_cs", ifc.Wb_cs, 1'b1);
    ifc.M1_cs = 1'b0;
    #1;
    chk("ab_wb_cs_drop", ifc.Wb_cs, 1'b0);
    chk("ab_m1_ack", ifc.M1_ack, 1'b0);
    cyc(); #1;
    chk("ab_idle_state", dbg_rr, 2'd0);
    chk("ab_idle_grant", ifc.Grant, 2'b00);
    man_ack = 1'b1;
    #1;
    chk("sp_m0_ack", ifc.M0_ack, 1'b0);
    chk("sp_m1_ack", ifc.M1_ack, 1'b0);
    cyc(); #1;
    chk("sp_state", dbg_rr, 2'd0);
    man_ack = 1'b0;

    // make M0 the last owner, then reset in the middle of an M1 transfer
    ifc.M0_cs = 1'b1; ifc.M0_addr = 32'h50; ifc.M0_we = 1'b0;
    cyc(); #1;
    chk("rm_m0_grant", ifc.Grant, 2'b01);
    man_ack = 1'b1;
    #1;
    chk("rm_m0_ack", ifc.M0_ack, 1'b1);
    cyc();
    man_ack = 1'b0; ifc.M0_cs = 1'b0;
    cyc();
    ifc.M1_cs = 1'b1; ifc.M1_addr = 32'h58;
    cyc(); #1;
    chk("rm_own1_grant", ifc.Grant, 2'b10);
    chk("rm_own1_wb_cs", ifc.Wb_cs, 1'b1);
    rst = 1'b1;
    cyc(); #1;
    chk("rm_wb_cs", ifc.Wb_cs, 1'b0);
    chk("rm_grant", ifc.Grant, 2'b00);
    chk("rm_state", dbg_rr, 2'd0);
    chk("rm_m1_ack", ifc.M1_ack, 1'b0);
    rst = 1'b0;
    ifc.M0_cs = 1'b1;
    cyc(); #1;
    chk("rm_tie_grant", ifc.Grant, 2'b01);
    ifc.M0_cs = 1'b0; ifc.M1_cs = 1'b0;
    cyc(); cyc();

`ifdef WB_ARB_TIMEOUT_EN
    // watchdog: M0 read, slave never acks
    man_rdata = 32'h1111_1111;
    ifc.M0_cs = 1'b1; ifc.M0_we = 1'b0; ifc.M0_addr = 32'h60;
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk("to_wait_ack", ifc.M0_ack, 1'b0);
      chk("to_wait_err", ifc.Timeout_err, 1'b0);
      chk("to_wait_wb_cs", ifc.Wb_cs, 1'b1);
    end
    cyc(); #1;
    chk("to_m0_ack", ifc.M0_ack, 1'b1);
    chk("to_m0_rdata", ifc.M0_rdata, 32'hDEAD_BEEF);
    chk("to_m1_rdata", ifc.M1_rdata, 32'h1111_1111);
    chk("to_err", ifc.Timeout_err, 1'b1);
    chk("to_wb_cs", ifc.Wb_cs, 1'b0);
    ifc.M0_cs = 1'b0;
    cyc(); #1;
    chk("to_rest_state", dbg_rr, 2'd3);
    chk("to_rest_err", ifc.Timeout_err, 1'b0);
    chk("to_rest_ack", ifc.M0_ack, 1'b0);
    cyc(); #1;
    chk("to_idle_state", dbg_rr, 2'd0);
`else
    // no watchdog: the grant is held while the slave stays silent
    ifc.M0_cs = 1'b1; ifc.M0_we = 1'b0; ifc.M0_addr = 32'h60;
    for (int i = 0; i < 10; i++) begin
      cyc(); #1;
      chk("hold_grant", ifc.Grant, 2'b01);
      chk("hold_err", ifc.Timeout_err, 1'b0);
      chk("hold_ack", ifc.M0_ack, 1'b0);
    end
    ifc.M0_cs = 1'b0;
    cyc(); #1;
    chk("hold_abort_state", dbg_rr, 2'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
